eadder_seq: RTL and testbench

Sequencer for the 39-bit accumulate adder (eadder). It runs one accumulation job per start command: clears the accumulator, adds a programmed number of 31-bit multiplier results accepted over a valid/ready handshake, optionally adds the 39-bit extended register operand, then captures and presents the final sum with an unsigned-wrap flag. It sits between the multiplier output stage and the eadder, and drives eadder_new, enable and eadder_sel.

---
 rtl/eadder_seq_if.sv | 42 ++++
 rtl/eadder_seq.sv | 175 +++++++++++++++++
 tb/tb_eadder_seq.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/eadder_seq_if.sv
// eadder_seq_if: bundles the job control, multiplier handshake, eadder
// control and result signals of the eadder sequencer.
//   slave  modport : the sequencer (eadder_seq)
//   master modport : whatever drives jobs / models the eadder (e.g. a bench)
// Signals:
//   start, cfg_len, cfg_add_ereg, abort : job control into the sequencer
//   mul_valid / mul_ready               : multiplier term handshake
//   busy                                : job in progress
//   eadder_new, eadder_en, eadder_sel   : eadder control
//   sum_in                              : eadder sum_out fed back
//   result, result_valid, ovf           : captured final sum and wrap flag
interface eadder_seq_if #(
    parameter int LEN_W = 8,
    parameter int SUM_W = 39
);
    logic             start;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_add_ereg;
    logic             abort;
    logic             mul_valid;
    logic             mul_ready;
    logic             busy;
    logic             eadder_new;
    logic             eadder_en;
    logic             eadder_sel;
    logic [SUM_W-1:0] sum_in;
    logic [SUM_W-1:0] result;
    logic             result_valid;
    logic             ovf;

    modport slave (
        input  start, cfg_len, cfg_add_ereg, abort, mul_valid, sum_in,
        output mul_ready, busy, eadder_new, eadder_en, eadder_sel,
               result, result_valid, ovf
    );

    modport master (
        output start, cfg_len, cfg_add_ereg, abort, mul_valid, sum_in,
        input  mul_ready, busy, eadder_new, eadder_en, eadder_sel,
               result, result_valid, ovf
    );
endinterface

// File: rtl/eadder_seq.sv
// eadder_seq: sequencer for the 39-bit accumulate adder. One job per start:
// clear the accumulator, add cfg_len multiplier terms taken over a
// valid/ready handshake, optionally add the extended register operand, then
// capture the final sum and flag an unsigned wrap of the ereg add.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : eadder_seq_if.slave (job control, handshake, eadder control,
//           eadder sum feedback, result/result_valid/ovf)
module eadder_seq #(
    parameter int LEN_W = 8,
    parameter int SUM_W = 39
) (
    input  logic          clk,
    input  logic          rst_n,
    eadder_seq_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_ACC  = 3'd2,
        ST_ADDE = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [SUM_W-1:0] SUM_ZERO = {SUM_W{1'b0}};

    state_t           state_r;
    state_t           state_nxt_s;
    logic [LEN_W-1:0] count_r;
    logic [LEN_W-1:0] len_r;
    logic             add_ereg_r;
    logic [SUM_W-1:0] snap_r;
    logic [SUM_W-1:0] result_r;
    logic             result_valid_r;
    logic             ovf_r;

    logic             abort_s;
    logic             mul_ready_s;
    logic             eadder_new_s;
    logic             eadder_en_s;
    logic             eadder_sel_s;
    logic             xfer_s;

    // abort is only meaningful while a job is running
    assign abort_s = bus.abort && (state_r != ST_IDLE);

    // Next-state and eadder/handshake control decode; abort overrides all.
    always_comb begin
        state_nxt_s  = state_r;
        mul_ready_s  = 1'b0;
        eadder_new_s = 1'b0;
        eadder_en_s  = 1'b0;
        eadder_sel_s = 1'b0;
        xfer_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt_s = ST_CLR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLR: begin
                eadder_new_s = 1'b1;
                if (abort_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (len_r != LEN_ZERO) begin
                    state_nxt_s = ST_ACC;
                end else if (add_ereg_r) begin
                    state_nxt_s = ST_ADDE;
                end else begin
                    state_nxt_s = ST_FIN;
                end
            end
            ST_ACC: begin
                if (abort_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    mul_ready_s = 1'b1;
                    if (bus.mul_valid) begin
                        xfer_s      = 1'b1;
                        eadder_en_s = 1'b1;
                        // last term: len_r >= 1 is guaranteed in ACC
                        if (count_r == (len_r - LEN_ONE)) begin
                            state_nxt_s = add_ereg_r ? ST_ADDE : ST_FIN;
                        end else begin
                            state_nxt_s = ST_ACC;
                        end
                    end else begin
                        state_nxt_s = ST_ACC;
                    end
                end
            end
            ST_ADDE: begin
                if (abort_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    eadder_en_s  = 1'b1;
                    eadder_sel_s = 1'b1;
                    state_nxt_s  = ST_FIN;
                end
            end
            ST_FIN: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Job configuration latch and term counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_r      <= LEN_ZERO;
            add_ereg_r <= 1'b0;
            count_r    <= LEN_ZERO;
        end else begin
            if ((state_r == ST_IDLE) && bus.start) begin
                len_r      <= bus.cfg_len;
                add_ereg_r <= bus.cfg_add_ereg;
            end
            if (state_r == ST_CLR) begin
                count_r <= LEN_ZERO;
            end else if (xfer_s) begin
                count_r <= count_r + LEN_ONE;
            end
        end
    end

    // Result capture. sum_in lags the eadder controls by one cycle, so the
    // ADDE-cycle value is the pure mul-term sum and the FIN-cycle value is
    // the final sum; a wrap on the ereg add shows as final < pre-ereg sum.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            snap_r         <= SUM_ZERO;
            result_r       <= SUM_ZERO;
            result_valid_r <= 1'b0;
            ovf_r          <= 1'b0;
        end else begin
            result_valid_r <= 1'b0;
            if ((state_r == ST_ADDE) && !abort_s) begin
                snap_r <= bus.sum_in;
            end
            if ((state_r == ST_FIN) && !abort_s) begin
                result_r       <= bus.sum_in;
                result_valid_r <= 1'b1;
                ovf_r          <= add_ereg_r && (bus.sum_in < snap_r);
            end
        end
    end

    assign bus.mul_ready    = mul_ready_s;
    assign bus.busy         = (state_r != ST_IDLE);
    assign bus.eadder_new   = eadder_new_s;
    assign bus.eadder_en    = eadder_en_s;
    assign bus.eadder_sel   = eadder_sel_s;
    assign bus.result       = result_r;
    assign bus.result_valid = result_valid_r;
    assign bus.ovf          = ovf_r;

endmodule

// File: tb/tb_eadder_seq.sv
// tb_eadder_seq: directed bench for eadder_seq. Contains a behavioural
// eadder (39-bit accumulator, one-cycle register latency) fed by the
// sequencer controls; expected results are hand-computed constants.
module tb_eadder_seq;

    logic        clk;
    logic        rst_n;
    logic [30:0] mul_data;
    logic [38:0] ereg;
    logic [38:0] acc_m;
    logic [30:0] terms [8];
    int          errors;
    int          checks;

    eadder_seq_if #(.LEN_W(8), .SUM_W(39)) bus ();

    eadder_seq #(.LEN_W(8), .SUM_W(39)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural eadder
    always @(posedge clk) begin
        if (!rst_n)              acc_m <= 39'd0;
        else if (bus.eadder_new) acc_m <= 39'd0;
        else if (bus.eadder_en)  acc_m <= acc_m + (bus.eadder_sel ? ereg : {8'd0, mul_data});
    end
    assign bus.sum_in = acc_m;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_terms(input logic [30:0] t0, input logic [30:0] t1,
                             input logic [30:0] t2, input logic [30:0] t3);
        terms[0] = t0; terms[1] = t1; terms[2] = t2; terms[3] = t3;
        for (int i = 4; i < 8; i++) terms[i] = 31'd0;
    endtask

    // Runs one job. hold keeps start high all job long (cfg_len junk except
    // nlen in the expected result_valid cycle); started skips the start
    // phase because the previous job's result_valid cycle already accepted it.
    task automatic run_job(input string name, input logic [7:0] len, input logic add_e,
                           input int bub, input logic hold, input logic started,
                           input logic [7:0] nlen, input logic [38:0] exp_res,
                           input logic exp_ovf, input int exp_lat);
        int idx = 0;
        int gap = 0;
        int lat = -1;
        int n_new = 0;
        int n_e0 = 0;
        int n_e1 = 0;
        int n_bad = 0;
        logic bsy = 1'b1;
        if (!started) begin
            @(negedge clk);
            bus.start = 1'b1;
            bus.cfg_len = len;
            bus.cfg_add_ereg = add_e;
            bus.mul_valid = 1'b0;
            #1;
            chk({name, "_idle_busy"}, {63'd0, bus.busy}, 64'd0);
        end
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            if (hold) begin
                bus.start = 1'b1;
                if (cyc == exp_lat) begin
                    bus.cfg_len = nlen;
                    bus.cfg_add_ereg = 1'b0;
                end else begin
                    bus.cfg_len = 8'd7;
                    bus.cfg_add_ereg = 1'b1;
                end
            end else begin
                bus.start = 1'b0;
            end
            if (idx < int'(len) && gap == 0) begin
                bus.mul_valid = 1'b1;
                mul_data = terms[idx];
            end else begin
                bus.mul_valid = 1'b0;
                if (gap > 0) gap--;
            end
            #1;
            if (bus.eadder_new) n_new++;
            if (bus.eadder_en && !bus.eadder_sel) n_e0++;
            if (bus.eadder_en && bus.eadder_sel) n_e1++;
            if (bus.eadder_sel && !bus.eadder_en) n_bad++;
            if (bus.mul_valid && bus.mul_ready) begin
                idx++;
                gap = bub;
            end
            if (bus.result_valid) begin
                lat = cyc;
                bsy = bus.busy;
                break;
            end
        end
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({name, "_new_cycles"}, 64'(n_new), 64'd1);
        chk({name, "_mul_adds"}, 64'(n_e0), 64'(len));
        chk({name, "_ereg_adds"}, 64'(n_e1), 64'(add_e));
        chk({name, "_sel_without_en"}, 64'(n_bad), 64'd0);
        chk({name, "_busy_at_valid"}, {63'd0, bsy}, 64'd0);
        chk({name, "_result"}, {25'd0, bus.result}, {25'd0, exp_res});
        chk({name, "_ovf"}, {63'd0, bus.ovf}, {63'd0, exp_ovf});
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_busy"}, {63'd0, bus.busy}, 64'd0);
        chk({name, "_mul_ready"}, {63'd0, bus.mul_ready}, 64'd0);
        chk({name, "_eadder_new"}, {63'd0, bus.eadder_new}, 64'd0);
        chk({name, "_eadder_en"}, {63'd0, bus.eadder_en}, 64'd0);
        chk({name, "_eadder_sel"}, {63'd0, bus.eadder_sel}, 64'd0);
        chk({name, "_result_valid"}, {63'd0, bus.result_valid}, 64'd0);
        chk({name, "_result"}, {25'd0, bus.result}, 64'd0);
        chk({name, "_ovf"}, {63'd0, bus.ovf}, 64'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.cfg_len = 8'd0;
        bus.cfg_add_ereg = 1'b0;
        bus.abort = 1'b0;
        bus.mul_valid = 1'b0;
        mul_data = 31'd0;
        ereg = 39'd0;
        set_terms(31'd0, 31'd0, 31'd0, 31'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // 10+20+30+40, no bubbles: 1+4+0+1 to FIN, valid one later
        set_terms(31'd10, 31'd20, 31'd30, 31'd40);
        run_job("basic", 8'd4, 1'b0, 0, 1'b0, 1'b0, 8'd0, 39'd100, 1'b0, 7);

        // abort on the 2nd of 5 terms while that term is offered
        set_terms(31'd1, 31'd2, 31'd3, 31'd4);
        @(negedge clk);
        bus.start = 1'b1; bus.cfg_len = 8'd5; bus.cfg_add_ereg = 1'b0;
        @(negedge clk);
        bus.start = 1'b0; bus.mul_valid = 1'b1; mul_data = 31'd1;
        @(negedge clk);
        #1;
        chk("abort_first_ready", {63'd0, bus.mul_ready}, 64'd1);
        @(negedge clk);
        mul_data = 31'd2; bus.abort = 1'b1;
        #1;
        chk("abort_ready", {63'd0, bus.mul_ready}, 64'd0);
        chk("abort_en", {63'd0, bus.eadder_en}, 64'd0);
        @(negedge clk);
        bus.abort = 1'b0; bus.mul_valid = 1'b0;
        #1;
        chk("abort_busy", {63'd0, bus.busy}, 64'd0);
        chk("abort_no_valid", {63'd0, bus.result_valid}, 64'd0);
        chk("abort_result_kept", {25'd0, bus.result}, 64'd100);
        chk("abort_ovf_kept", {63'd0, bus.ovf}, 64'd0);

        // fresh job after abort: accumulator must start from zero
        set_terms(31'd7, 31'd8, 31'd0, 31'd0);
        run_job("post_abort", 8'd2, 1'b0, 0, 1'b0, 1'b0, 8'd0, 39'd15, 1'b0, 5);

        // 1,2,3 with 2-cycle bubbles, plus ereg 1000
        ereg = 39'd1000;
        set_terms(31'd1, 31'd2, 31'd3, 31'd0);
        run_job("bubbles", 8'd3, 1'b1, 2, 1'b0, 1'b0, 8'd0, 39'd1006, 1'b0, 11);

        // len=0: ereg only; then 1 + max ereg wraps to 0
        ereg = 39'h7F_FFFF_FFFF;
        run_job("ereg_only", 8'd0, 1'b1, 0, 1'b0, 1'b0, 8'd0, 39'h7F_FFFF_FFFF, 1'b0, 4);
        set_terms(31'd1, 31'd0, 31'd0, 31'd0);
        run_job("wrap", 8'd1, 1'b1, 0, 1'b0, 1'b0, 8'd0, 39'd0, 1'b1, 5);

        // start held high: one job of 5+6, second (len=1, 9) taken at result_valid
        set_terms(31'd5, 31'd6, 31'd0, 31'd0);
        run_job("hold_first", 8'd2, 1'b0, 0, 1'b1, 1'b0, 8'd1, 39'd11, 1'b0, 5);
        set_terms(31'd9, 31'd0, 31'd0, 31'd0);
        run_job("hold_second", 8'd1, 1'b0, 0, 1'b0, 1'b1, 8'd0, 39'd9, 1'b0, 4);

        // reset for one cycle mid-ACC
        set_terms(31'd10, 31'd20, 31'd30, 31'd40);
        @(negedge clk);
        bus.start = 1'b1; bus.cfg_len = 8'd4; bus.cfg_add_ereg = 1'b0;
        @(negedge clk);
        bus.start = 1'b0; bus.mul_valid = 1'b1; mul_data = 31'd10;
        @(negedge clk);
        mul_data = 31'd10;
        @(negedge clk);
        mul_data = 31'd20;
        @(negedge clk);
        mul_data = 31'd30; rst_n = 1'b0;
        #1;
        chk("pre_reset_busy", {63'd0, bus.busy}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_all_zero("mid_reset");

        @(negedge clk);
        bus.mul_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
